// File: rtl/fir_pkg.sv
// Shared definitions for the FIR input loader: controller states and
// the sticky error codes reported to software.
package fir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_FIRE   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ZERO    = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_ABORT   = 2'd3
    } err_t;

    // Shared width of the fire-length / timeout cycle counter.
    localparam int CNT_W = 16;

endpackage

// File: rtl/fir_input_loader.sv
// FIR input loader: streams sample_count beats into memory port A starting
// at base_addr (wrapping silently), pulses fir_start, then waits for
// fir_done with a bounded timeout. All outputs are registered.
module fir_input_loader
    import fir_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8,
    parameter int START_LEN = 10,
    parameter int TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] sample_count,
    input  logic              abort,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              fir_start,
    input  logic              fir_done,
    output logic              busy,
    output logic              complete,
    output logic [1:0]        error
);

    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  FIRE_LAST = CNT_W'(START_LEN);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    err_t              err_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] index;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              last_beat;

    // s_ready is only ever high in LOAD, so it alone qualifies a beat.
    assign accept    = s_ready && s_valid;
    assign last_beat = (index == count_q - ONE);
    assign error     = err_q;

    // Job controller: state, registered handshake/status outputs and the
    // one-cycle-delayed memory write of every accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            err_q     <= ERR_NONE;
            base_q    <= '0;
            count_q   <= '0;
            index     <= '0;
            cnt       <= '0;
            s_ready   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            fir_start <= 1'b0;
            busy      <= 1'b0;
            complete  <= 1'b0;
        end else begin
            // A beat accepted in any cycle (including an abort cycle) is
            // written on the following cycle.
            mem_we   <= accept;
            complete <= 1'b0;
            if (accept) begin
                mem_addr  <= base_q + index;
                mem_wdata <= s_data;
            end

            case (state)
                ST_IDLE: begin
                    if (load_req) begin
                        base_q  <= base_addr;
                        count_q <= sample_count;
                        index   <= '0;
                        cnt     <= '0;
                        if (sample_count == '0) begin
                            err_q <= ERR_ZERO;
                        end else begin
                            err_q   <= ERR_NONE;
                            state   <= ST_LOAD;
                            s_ready <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (abort) begin
                        state   <= ST_IDLE;
                        err_q   <= ERR_ABORT;
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                    end else if (accept) begin
                        index <= index + ONE;
                        if (last_beat) begin
                            state   <= ST_FIRE;
                            s_ready <= 1'b0;
                            cnt     <= '0;
                        end
                    end
                end

                // First FIRE cycle carries the last write; fir_start then
                // stays high while cnt runs 1..START_LEN.
                ST_FIRE: begin
                    if (abort) begin
                        state     <= ST_IDLE;
                        err_q     <= ERR_ABORT;
                        fir_start <= 1'b0;
                        busy      <= 1'b0;
                    end else if (cnt == FIRE_LAST) begin
                        fir_start <= 1'b0;
                        state     <= ST_WAIT;
                        cnt       <= '0;
                    end else begin
                        fir_start <= 1'b1;
                        cnt       <= cnt + 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        err_q <= ERR_ABORT;
                        busy  <= 1'b0;
                    end else if (fir_done) begin
                        state    <= ST_FINISH;
                        complete <= 1'b1;
                    end else if (cnt == WAIT_LAST) begin
                        state <= ST_IDLE;
                        err_q <= ERR_TIMEOUT;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_FINISH: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state     <= ST_IDLE;
                    s_ready   <= 1'b0;
                    fir_start <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fir_input_loader.md
FIR_INPUT_LOADER -- requirements
Module: fir_input_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, sample width.
REQ-003 SHALL have parameter START_LEN, default 10, fir_start pulse length in cycles (range 1..255).
REQ-004 SHALL have parameter TIMEOUT, default 4096, max cycles waiting for fir_done (range 1..65535).
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port load_req  input  1  begin a load-and-run job (sampled in IDLE only).
REQ-008 SHALL have port base_addr  input  ADDR_W  first memory address for input samples.
REQ-009 SHALL have port sample_count  input  ADDR_W  number of samples to load.
REQ-010 SHALL have port abort  input  1  cancel current job.
REQ-011 SHALL have port s_data  input  DATA_W  incoming sample.
REQ-012 SHALL have port s_valid  input  1  s_data valid.
REQ-013 SHALL have port s_ready  output  1  loader accepts a sample this cycle.
REQ-014 SHALL have port mem_we  output  1  write enable to memory port A.
REQ-015 SHALL have port mem_addr  output  ADDR_W  memory port A address.
REQ-016 SHALL have port mem_wdata  output  DATA_W  memory port A write data.
REQ-017 SHALL have port fir_start  output  1  start to FIR top.
REQ-018 SHALL have port fir_done  input  1  done level from FIR top.
REQ-019 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-020 SHALL have port complete  output  1  one-cycle pulse on successful job end.
REQ-021 SHALL have port error  output  2  sticky code: 0 none, 1 zero count, 2 timeout, 3 aborted; cleared on next accepted load_req.

Function
REQ-022 SHALL implement states IDLE, LOAD, FIRE, WAIT, FINISH.
REQ-023 IDLE: on load_req, latch base_addr and sample_count; count 0 -> stay IDLE, error=1; else -> LOAD, index=0.
REQ-024 LOAD: s_ready=1; beat accepted when s_valid&&s_ready; s_ready=0 in every other state.
REQ-025 Each accepted beat SHALL produce, on the next cycle, mem_we=1, mem_addr=(base+index) mod 2^ADDR_W, mem_wdata=beat data; mem_we=0 otherwise.
REQ-026 Address wrap-around past 2^ADDR_W-1 to 0 SHALL be silent, no error.
REQ-027 After accepting beat index count-1, SHALL go to FIRE the following cycle; s_ready low from that cycle on.
REQ-028 FIRE: fir_start=1 for exactly START_LEN cycles, first cycle after last mem_we; then -> WAIT.
REQ-029 WAIT: fir_start=0; 16-bit counter increments per cycle; fir_done=1 -> FINISH; counter reaching TIMEOUT with fir_done=0 -> IDLE, error=2.
REQ-030 FINISH: complete=1 for one cycle, -> IDLE.
REQ-031 abort in LOAD/FIRE/WAIT SHALL return to IDLE next cycle with error=3, fir_start=0, s_ready=0; a beat accepted in the abort cycle is still written; abort in IDLE ignored.
REQ-032 abort and final-beat acceptance in same cycle: abort wins.
REQ-033 load_req outside IDLE SHALL be ignored.

Reset
REQ-034 rst SHALL asynchronously force IDLE, index=0, counter=0, error=0, and s_ready, mem_we, fir_start, busy, complete all 0; mem_addr, mem_wdata 0.
REQ-035 rst mid-job SHALL drop fir_start immediately; no partial state retained.

Structure
REQ-036 State encoding and error codes SHALL live in shared package fir_pkg.
REQ-037 Single module, no sub-modules; memory and fir_top stay external.

Verification
REQ-038 base=0, count=20, 20 back-to-back beats -> mem[0..19] written in order, fir_start high 10 cycles, fir_done -> complete pulse, busy low.
REQ-039 base=1020, count=8 -> writes to 1020..1023 then 0..3, error=0.
REQ-040 count=0 load_req -> busy never rises, error=1, no mem_we.
REQ-041 fir_done held 0, TIMEOUT=100 -> return to IDLE 100 cycles after FIRE ends, error=2, no complete.
REQ-042 abort after 5 of 20 beats -> exactly 5 writes, fir_start never high, error=3.
REQ-043 s_valid toggled 50% gaps, count=16 -> 16 writes, identical memory image to back-to-back case.
